// File: rtl/hit_pad_pkg.sv
// Shared constants and the priority helper for the whack-a-mole pad front end.
package hit_pad_pkg;

  localparam int N_PADS          = 9;
  localparam int POS_W           = 4;
  localparam int DEBOUNCE_CYCLES = 1_000_000;

  localparam logic [POS_W-1:0] NONE_CODE = 4'd15;

  // Lowest set index wins; an empty vector yields NONE_CODE.
  function automatic logic [POS_W-1:0] lowest_index(input logic [N_PADS-1:0] v);
    lowest_index = NONE_CODE;
    for (int i = N_PADS - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = POS_W'(i);
    end
  endfunction

endpackage

// File: rtl/pad_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge detect for one button.
// Build option HIT_PAD_ACTIVE_LOW_EN: raw input is pressed-low (pull-up buttons).
module pad_debouncer #(
  parameter int DEBOUNCE_CYCLES = hit_pad_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             raw_in;
  logic             s1;
  logic             s2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

`ifdef HIT_PAD_ACTIVE_LOW_EN
  // Inverting ahead of the flops makes a zero reset equal to an idle (high) button.
  assign raw_in = ~raw;
`else
  assign raw_in = raw;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw_in;
      s2       <= s1;
      stable_d <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_d;

endmodule

// File: rtl/hit_pad_encoder.sv
// Pad/start front end: debounced inputs, pending-hit queue and one-per-cycle priority arbiter.
// Build option HIT_PAD_ACTIVE_LOW_EN selects pressed-low buttons (handled in pad_debouncer).
module hit_pad_encoder
  import hit_pad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = hit_pad_pkg::DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_PADS-1:0] pad_raw,
  input  logic              start_raw,
  input  logic              game_active,
  output logic [POS_W-1:0]  hit_pos,
  output logic              start_pulse,
  output logic [N_PADS-1:0] pad_level
);

  logic [N_PADS-1:0] pad_rise;
  logic              start_rise;
  logic              start_level;
  logic [N_PADS-1:0] pending;
  logic [N_PADS-1:0] pending_next;
  logic [N_PADS-1:0] grant;
  logic [POS_W-1:0]  pos_next;

  for (genvar i = 0; i < N_PADS; i++) begin : g_pad
    pad_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pad (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (pad_raw[i]),
      .level (pad_level[i]),
      .rise  (pad_rise[i])
    );
  end

  pad_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (start_raw),
    .level (start_level),
    .rise  (start_rise)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant        = '0;
    pos_next     = NONE_CODE;
    pending_next = pending | pad_rise;
    if (!game_active) begin
      pending_next = '0;
    end else if (pending != '0) begin
      // Isolate the lowest set bit; a same-cycle rise on that pad re-arms it.
      grant        = pending & (~pending + N_PADS'(1));
      pos_next     = lowest_index(pending);
      pending_next = (pending & ~grant) | pad_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      hit_pos     <= NONE_CODE;
      start_pulse <= 1'b0;
    end else begin
      pending     <= pending_next;
      hit_pos     <= pos_next;
      start_pulse <= start_rise;
    end
  end

endmodule

// File: tb/tb_hit_pad_encoder.sv
// Directed bench for hit_pad_encoder with a 4-cycle debounce window.
module tb_hit_pad_encoder;
  import hit_pad_pkg::*;

  localparam int DEB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_PADS-1:0] pad_raw;
  logic              start_raw;
  logic              game_active;
  logic [POS_W-1:0]  hit_pos;
  logic              start_pulse;
  logic [N_PADS-1:0] pad_level;

  int passed = 0;
  int total  = 0;

  hit_pad_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_raw     (pad_raw),
    .start_raw   (start_raw),
    .game_active (game_active),
    .hit_pos     (hit_pos),
    .start_pulse (start_pulse),
    .pad_level   (pad_level)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    pad_raw     = '0;
    start_raw   = 1'b0;
    game_active = 1'b0;
    idle(3);
    total++;
    if (hit_pos !== NONE_CODE || start_pulse !== 1'b0 || pad_level !== '0)
      $display("FAIL reset_init: hit_pos=%0d start_pulse=%0b pad_level=%b, want 15/0/0",
               hit_pos, start_pulse, pad_level);
    else passed++;
    rst_n = 1'b1;
    idle(2);
    // Mid-run: press pad 3 and start, then reset while start_pulse is high.
    pad_raw[3] = 1'b1;
    start_raw  = 1'b1;
    idle(DEB + 3);
    total++;
    if (start_pulse !== 1'b1 || pad_level !== 9'b000001000)
      $display("FAIL reset_pre: start_pulse=%0b pad_level=%b, want 1/000001000",
               start_pulse, pad_level);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (hit_pos !== NONE_CODE || start_pulse !== 1'b0 || pad_level !== '0)
      $display("FAIL reset_async: hit_pos=%0d start_pulse=%0b pad_level=%b, want 15/0/0",
               hit_pos, start_pulse, pad_level);
    else passed++;
    pad_raw   = '0;
    start_raw = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single_hit();
    game_active = 1'b1;
    pad_raw[4]  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (hit_pos !== ((k == DEB + 4) ? 4'd4 : NONE_CODE))
        $display("FAIL single_hit cycle %0d: hit_pos=%0d want %0d", k, hit_pos,
                 (k == DEB + 4) ? 4 : 15);
      else passed++;
    end
    total++;
    if (pad_level[4] !== 1'b1) $display("FAIL single_level: pad_level[4]=%0b want 1", pad_level[4]);
    else passed++;
    pad_raw[4] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if (hit_pos !== NONE_CODE) $display("FAIL single_release cycle %0d: hit_pos=%0d want 15", k, hit_pos);
      else passed++;
    end
    total++;
    if (pad_level[4] !== 1'b0) $display("FAIL single_release_level: pad_level[4]=%0b want 0", pad_level[4]);
    else passed++;
  endtask

  task automatic test_glitch();
    pad_raw[2] = 1'b1;
    idle(3);
    pad_raw[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if (hit_pos !== NONE_CODE || pad_level[2] !== 1'b0)
        $display("FAIL glitch cycle %0d: hit_pos=%0d pad_level[2]=%0b want 15/0", k, hit_pos, pad_level[2]);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    logic [POS_W-1:0] want;
    pad_raw[1] = 1'b1;
    pad_raw[7] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      want = (k == DEB + 4) ? 4'd1 : (k == DEB + 5) ? 4'd7 : NONE_CODE;
      total++;
      if (hit_pos !== want) $display("FAIL simultaneous cycle %0d: hit_pos=%0d want %0d", k, hit_pos, want);
      else passed++;
    end
    pad_raw = '0;
    idle(10);
  endtask

  task automatic test_gated();
    game_active = 1'b0;
    pad_raw[5]  = 1'b1;
    for (int k = 1; k <= DEB + 5; k++) begin
      step();
      total++;
      if (hit_pos !== NONE_CODE) $display("FAIL gated_off cycle %0d: hit_pos=%0d want 15", k, hit_pos);
      else passed++;
    end
    total++;
    if (pad_level[5] !== 1'b1) $display("FAIL gated_level: pad_level[5]=%0b want 1", pad_level[5]);
    else passed++;
    game_active = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (hit_pos !== NONE_CODE) $display("FAIL gated_on cycle %0d: hit_pos=%0d want 15", k, hit_pos);
      else passed++;
    end
    pad_raw[5] = 1'b0;
    idle(10);
  endtask

  task automatic test_start();
    game_active = 1'b0;
    start_raw   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) start_raw = 1'b0;
      step();
      total++;
      if (start_pulse !== (k == DEB + 3))
        $display("FAIL start cycle %0d: start_pulse=%0b want %0b", k, start_pulse, (k == DEB + 3));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_glitch();
    test_simultaneous();
    test_gated();
    test_start();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
